// File: rtl/multibyte_add_pkg.sv
// rtl/multibyte_add_pkg.sv - shared types and constants for the sequential multi-byte adder
package multibyte_add_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the single adder slice the word is streamed through
  localparam int BYTE_W = 8;

  // Supported operand sizes, in bytes
  localparam int NBYTES_MIN = 2;
  localparam int NBYTES_MAX = 16;

endpackage

// File: rtl/byte_add_stage.sv
// rtl/byte_add_stage.sv - combinational 8-bit add slice with carry and signed overflow
module byte_add_stage
  import multibyte_add_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co,
  output logic              ov
);

  logic [BYTE_W:0] full;
  logic            c_msb;

  // Plain ripple add; the carry into the top bit is recovered from the sum bit
  always_comb begin
    full  = {1'b0, x} + {1'b0, y} + {{BYTE_W{1'b0}}, ci};
    s     = full[BYTE_W-1:0];
    co    = full[BYTE_W];
    c_msb = x[BYTE_W-1] ^ y[BYTE_W-1] ^ full[BYTE_W-1];
    ov    = c_msb ^ full[BYTE_W];
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - byte-serial wide adder front end (optional SUBTRACT_EN adds a sub port)
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
`ifdef SUBTRACT_EN
  input  logic                     sub,
`endif
  input  logic                     cin,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry;

  logic [W-1:0]       b_in;
  logic               c_in;
  logic [IDX_W+2:0]   bit_off;
  logic [BYTE_W-1:0]  x;
  logic [BYTE_W-1:0]  y;
  logic [BYTE_W-1:0]  s;
  logic               co;
  logic               ov;

  // Subtraction is a+~b+1, so only the latched B and initial carry change
`ifdef SUBTRACT_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  // Byte lane currently being processed (BYTE_W is 8, so idx*8)
  assign bit_off = {idx, 3'b000};
  assign x       = a_q[bit_off +: BYTE_W];
  assign y       = b_q[bit_off +: BYTE_W];

  byte_add_stage u_stage (
    .x  (x),
    .y  (y),
    .ci (carry),
    .s  (s),
    .co (co),
    .ov (ov)
  );

  // Controller, byte counter, operand capture and sum assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b_in;
            carry <= c_in;
            sum   <= '0;
            idx   <= '0;
            state <= BUSY;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        BUSY: begin
          sum[bit_off +: BYTE_W] <= s;
          carry <= co;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout  <= co;
            ovf   <= ov;
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - scoreboard bench for multibyte_add_seq with a word-level reference model
module tb_multibyte_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
`ifdef SUBTRACT_EN
  logic         sub   = 1'b0;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SUBTRACT_EN
    .sub   (sub),
`endif
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   last_done = -1;
  int   prev_done = -1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Word-level reference: the whole operation as one wide addition
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xc, input logic xs);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         c;
    bb     = xs ? ~xb : xb;
    c      = xs ? 1'b1 : xc;
    full   = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, c};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (xa[W-1] == bb[W-1]) && (full[W-1] != xa[W-1]);
    e.acc  = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done) begin
      prev_done = last_done;
      last_done = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("sum", sum, mon_e.sum);
        check("cout", W'(cout), W'(mon_e.cout));
        check("ovf", W'(ovf), W'(mon_e.ovf));
        check("latency", W'(cyc - mon_e.acc), W'(NBYTES + 1));
      end
    end
  end

  // Called at a negedge; waits for ready, presents one request for one cycle
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input logic xs, input bit expect_done);
    int   n;
    exp_t e;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
    a   = xa;
    b   = xb;
    cin = xc;
`ifdef SUBTRACT_EN
    sub = xs;
    e   = model(xa, xb, xc, xs);
`else
    e   = model(xa, xb, xc, 1'b0);
`endif
    e.acc = cyc;
    start = 1'b1;
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // While the DUT is busy, scramble inputs and pulse start; none of it may matter
  task automatic busy_noise();
    int n;
    n = 0;
    while (!ready && n < 50) begin
      a     = $urandom;
      b     = $urandom;
      cin   = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", W'(ready), W'(1));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_sum", sum, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf", W'(ovf), W'(0));

    issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    drain();
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    issue(32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b1);
    busy_noise();
    drain();

    issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1);
    issue(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1);
    busy_noise();
    drain();
    check("b2b_spacing", W'(last_done - prev_done), W'(NBYTES + 1));

    // Abort in the second busy cycle: no done, registers back to reset values
    issue(32'h00000011, 32'h00000022, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", W'(ready), W'(1));
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_sum", sum, '0);
    check("abort_cout", W'(cout), W'(0));
    check("abort_ovf", W'(ovf), W'(0));
    repeat (8) @(negedge clk);

`ifdef SUBTRACT_EN
    issue(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b1);
    issue(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1);
    drain();
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ~ra;
      issue(ra, rb, rc, rs, 1'b1);
      if ($urandom_range(0, 1) == 1) busy_noise();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("queue_empty", W'(sb.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
